// File: rtl/csv_pkg.sv
// Shared definitions for the streaming CSV record parser: ASCII constants,
// parser states and the per-byte classifier.
package csv_pkg;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SP    = 8'h20;

  typedef enum logic [1:0] {
    LINE_START = 2'd0,
    FIELD      = 2'd1,
    SKIP       = 2'd2,
    EMIT       = 2'd3
  } csv_state_e;

  typedef enum logic [2:0] {
    CL_DIGIT, CL_MINUS, CL_COMMA, CL_LF, CL_IGN, CL_BAD
  } csv_class_e;

  function automatic csv_class_e classify(input logic [7:0] b);
    csv_class_e c;
    if (b >= CH_0 && b <= CH_9) c = CL_DIGIT;
    else begin
      case (b)
        CH_MINUS:     c = CL_MINUS;
        CH_COMMA:     c = CL_COMMA;
        CH_LF:        c = CL_LF;
        CH_CR, CH_SP: c = CL_IGN;
        default:      c = CL_BAD;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/csv_digit_accum.sv
// Decimal field accumulator: acc*10+d modulo 2^FIELD_W, plus a sign flag.
// Reports whether any digit has been seen so the parent can reject empty fields.
module csv_digit_accum #(
  parameter int FIELD_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_digit_en,
  input  logic [3:0]         i_digit,
  input  logic               i_neg,
  output logic [FIELD_W-1:0] o_value,
  output logic               o_neg,
  output logic               o_has_digit
);

  logic [FIELD_W-1:0] r_acc;
  logic               r_neg;
  logic               r_has;
  logic [FIELD_W-1:0] w_next;

  // acc*10 as (acc<<3)+(acc<<1) keeps everything at FIELD_W, wrapping naturally
  assign w_next = (r_acc << 3) + (r_acc << 1) + {{(FIELD_W-4){1'b0}}, i_digit};

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_acc <= '0;
      r_neg <= 1'b0;
      r_has <= 1'b0;
    end else begin
      if (i_digit_en) begin
        r_acc <= w_next;
        r_has <= 1'b1;
      end
      if (i_neg) r_neg <= 1'b1;
    end
  end

  assign o_value     = r_neg ? (~r_acc + 1'b1) : r_acc;
  assign o_neg       = r_neg;
  assign o_has_digit = r_has;

endmodule

// File: rtl/csv_record_parser.sv
// Streaming CSV line parser: one ASCII byte per cycle in, NUM_FIELDS-field records out.
// Optional build macro CSV_HEADER_SKIP_EN discards the first non-empty line after reset.
module csv_record_parser
  import csv_pkg::*;
#(
  parameter int NUM_FIELDS = 5,
  parameter int FIELD_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_FIELDS*FIELD_W-1:0] out_fields,
  output logic                          err_pulse,
  output logic [15:0]                   rec_count
);

  localparam int              IDX_W    = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS-1);

  csv_state_e                         r_state;
  logic [IDX_W-1:0]                   r_idx;
  logic [NUM_FIELDS-2:0][FIELD_W-1:0] r_stage;
  logic [NUM_FIELDS*FIELD_W-1:0]      r_out;
  logic [15:0]                        r_rec_count;
  logic                               r_skip_err;

  csv_class_e         w_cls;
  logic               w_fire, w_parse, w_last, w_bad, w_hdr, w_tok, w_sep, w_lf_ok;
  logic [FIELD_W-1:0] w_val;
  logic               w_neg, w_has;

  assign in_ready  = (r_state != EMIT);
  assign out_valid = (r_state == EMIT);
  assign w_fire    = in_valid & in_ready;
  assign w_cls     = classify(in_data);
  assign w_parse   = (r_state == LINE_START) | (r_state == FIELD);
  assign w_last    = (r_idx == LAST_IDX);

  always_comb begin
    w_bad = 1'b0;
    case (w_cls)
      CL_BAD:   w_bad = 1'b1;
      CL_MINUS: w_bad = w_has | w_neg;
      CL_COMMA: w_bad = ~w_has | w_last;
      CL_LF:    w_bad = (r_state == FIELD) & (~w_has | ~w_last);
      default:  w_bad = 1'b0;
    endcase
  end

`ifdef CSV_HEADER_SKIP_EN
  logic r_hdr;
  always_ff @(posedge clk) begin
    if (rst)        r_hdr <= 1'b1;
    else if (w_hdr) r_hdr <= 1'b0;
  end
  assign w_hdr = w_fire & r_hdr & (r_state == LINE_START) & (w_cls != CL_IGN) & (w_cls != CL_LF);
`else
  assign w_hdr = 1'b0;
`endif

  // w_tok: accepted byte that is interpreted as CSV content
  assign w_tok     = w_fire & w_parse & ~w_hdr;
  assign w_sep     = w_tok & (w_cls == CL_COMMA) & ~w_bad;
  assign w_lf_ok   = w_tok & (w_cls == CL_LF) & (r_state == FIELD) & ~w_bad;
  assign err_pulse = ~rst & w_fire & (w_cls == CL_LF) &
                     (((r_state == SKIP) & r_skip_err) | (w_tok & w_bad));

  csv_digit_accum #(.FIELD_W(FIELD_W)) u_acc (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_fire & ((w_cls == CL_COMMA) | (w_cls == CL_LF))),
    .i_digit_en  (w_tok & (w_cls == CL_DIGIT)),
    .i_digit     (in_data[3:0]),
    .i_neg       (w_tok & (w_cls == CL_MINUS) & ~w_bad),
    .o_value     (w_val),
    .o_neg       (w_neg),
    .o_has_digit (w_has)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LINE_START;
      r_idx       <= '0;
      r_stage     <= '0;
      r_out       <= '0;
      r_rec_count <= '0;
      r_skip_err  <= 1'b0;
    end else begin
      case (r_state)
        LINE_START, FIELD: if (w_fire) begin
          if (w_hdr) begin
            r_state    <= SKIP;
            r_skip_err <= 1'b0;
          end else if (w_cls == CL_LF) begin
            r_idx <= '0;
            if (r_state == FIELD) r_state <= w_bad ? LINE_START : EMIT;
          end else if (w_bad) begin
            r_state    <= SKIP;
            r_skip_err <= 1'b1;
          end else if (w_cls != CL_IGN) begin
            r_state <= FIELD;
            if (w_cls == CL_COMMA) r_idx <= r_idx + 1'b1;
          end
        end
        SKIP: if (w_fire && w_cls == CL_LF) begin
          r_state <= LINE_START;
          r_idx   <= '0;
        end
        EMIT: if (out_ready) begin
          r_state     <= LINE_START;
          r_rec_count <= r_rec_count + 16'd1;
        end
        default: r_state <= LINE_START;
      endcase
      // fields land in staging first so a discarded line never disturbs out_fields
      for (int k = 0; k < NUM_FIELDS-1; k++)
        if (w_sep && r_idx == IDX_W'(k)) r_stage[k] <= w_val;
      if (w_lf_ok) r_out <= {w_val, r_stage};
    end
  end

  assign out_fields = r_out;
  assign rec_count  = r_rec_count;

endmodule

// File: tb/tb_csv_record_parser.sv
// Self-checking bench for csv_record_parser: table of CSV lines with expected
// records/errors, scoreboard of expected records, plus backpressure and reset sequences.
module tb_csv_record_parser;
  localparam int NF = 5;
  localparam int FW = 16;
  typedef logic [NF-1:0][FW-1:0] rec_t;
  typedef struct { string line; bit good; bit bad; rec_t f; } vec_t;

  logic           clk = 1'b0;
  logic           rst, in_valid, out_ready, in_ready, out_valid, err_pulse;
  logic [7:0]     in_data;
  logic [NF*FW-1:0] out_fields;
  logic [15:0]    rec_count;

  int   checks = 0, errors = 0, act_err = 0, exp_err = 0, exp_rec = 0;
  rec_t sb[$];
  rec_t last_rec = '0;
  vec_t vt[$];

  always #5 clk = ~clk;

  csv_record_parser #(.NUM_FIELDS(NF), .FIELD_W(FW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_fields(out_fields),
    .err_pulse(err_pulse), .rec_count(rec_count)
  );

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string s, input bit good, input bit bad,
                              input int a, input int b, input int c, input int d, input int e);
    vec_t v;
    v.line = s; v.good = good; v.bad = bad;
    v.f[0] = 16'(a); v.f[1] = 16'(b); v.f[2] = 16'(c); v.f[3] = 16'(d); v.f[4] = 16'(e);
    return v;
  endfunction

  // called at posedge+1; returns at posedge+1 right after the byte is accepted
  task automatic send_byte(input byte b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && n < 200) begin n++; @(negedge clk); end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1 within 200 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  // monitor: errors counted on accepted bytes, records popped on output handshake
  always @(negedge clk) begin
    rec_t e;
    if (!rst) begin
      if (in_valid && in_ready && err_pulse) act_err++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_record: got %0h expected none", out_fields);
        end else begin
          e = sb.pop_front();
          chk("record", out_fields, e);
        end
      end
    end
  end

  initial begin
    bit   hdr_bad;
    rec_t bp;
    int   rc;
`ifdef CSV_HEADER_SKIP_EN
    hdr_bad = 1'b0;
`else
    hdr_bad = 1'b1;
`endif
    vt.push_back(mk("a,b,c,d,e\n",                  0, hdr_bad, 0, 0, 0, 0, 0));
    vt.push_back(mk("1,-2,30,400,5\n",              1, 0, 1, -2, 30, 400, 5));
    vt.push_back(mk("1,2,3\n",                      0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk("1,2,3,4,5,6\n",                0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk("1,x,3,4,5\n",                  0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk("1,2-,3,4,5\n",                 0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk("0,0,0,0,0\n",                  1, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk("65536,70000,-32768,32767,0\n", 1, 0, 0, 4464, -32768, 32767, 0));
    vt.push_back(mk("\n\015\n",                     0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(" 12, -3 ,4,5,6\015\n",         1, 0, 12, -3, 4, 5, 6));
    vt.push_back(mk("1,,3,4,5\n",                   0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk("1,2,3,4,\n",                   0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk("--1,2,3,4,5\n",                0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk("99999,1,2,3,4\n",              1, 0, 34463, 1, 2, 3, 4));

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",   80'(in_ready),   80'(1));
    chk("rst_out_valid",  80'(out_valid),  80'(0));
    chk("rst_out_fields", 80'(out_fields), 80'(0));
    chk("rst_err_pulse",  80'(err_pulse),  80'(0));
    chk("rst_rec_count",  80'(rec_count),  80'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].good) begin
        sb.push_back(vt[i].f);
        last_rec = vt[i].f;
        exp_rec++;
      end
      if (vt[i].bad) exp_err++;
      send_line(vt[i].line);
      @(negedge clk);
      if (vt[i].good) chk("latency_out_valid", 80'(out_valid), 80'(1));
      repeat (2) @(negedge clk);
      chk("err_count",   80'(act_err),    80'(exp_err));
      chk("rec_count",   80'(rec_count),  80'(exp_rec));
      chk("fields_hold", 80'(out_fields), 80'(last_rec));
      chk("sb_drained",  80'(sb.size()),  80'(0));
      @(posedge clk); #1;
    end

    // backpressure: record held for 20 cycles with out_ready low
    out_ready = 1'b0;
    bp = mk("", 1, 0, 7, 8, 9, 10, 11).f;
    sb.push_back(bp);
    send_line("7,8,9,10,11\015\n");
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("stall_in_ready",   80'(in_ready),   80'(0));
      chk("stall_out_valid",  80'(out_valid),  80'(1));
      chk("stall_out_fields", 80'(out_fields), 80'(bp));
    end
    rc = exp_rec;
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("hs_rec_count_before", 80'(rec_count), 80'(rc));
    @(negedge clk);
    exp_rec++;
    chk("hs_rec_count_after", 80'(rec_count), 80'(exp_rec));
    chk("hs_out_valid_drop",  80'(out_valid), 80'(0));
    chk("hs_in_ready_back",   80'(in_ready),  80'(1));
    @(posedge clk); #1;
    last_rec = mk("", 1, 0, 1, 2, 3, 4, 5).f;
    sb.push_back(last_rec);
    exp_rec++;
    send_line("1,2,3,4,5\n");
    repeat (3) @(negedge clk);
    chk("post_stall_rec_count", 80'(rec_count),  80'(exp_rec));
    chk("post_stall_fields",    80'(out_fields), 80'(last_rec));
    @(posedge clk); #1;

    // reset mid-line drops the partial line and clears the count
    send_line("1,2,3");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rec = 0;
    @(negedge clk);
    chk("midrst_out_fields", 80'(out_fields), 80'(0));
    chk("midrst_rec_count",  80'(rec_count),  80'(0));
    @(posedge clk); #1;
`ifdef CSV_HEADER_SKIP_EN
    send_line("h,x\n");
`endif
    last_rec = mk("", 1, 0, 4, 5, 6, 7, 8).f;
    sb.push_back(last_rec);
    exp_rec++;
    send_line("4,5,6,7,8\n");
    repeat (3) @(negedge clk);
    chk("midrst_rec_after", 80'(rec_count), 80'(exp_rec));
    chk("final_err_count",  80'(act_err),   80'(exp_err));
    chk("final_sb_empty",   80'(sb.size()), 80'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
